// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, frame constants and the
// round-robin index wrap helper for the UART TX scheduler.
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_DEF_CLK_DIV = 10416;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Explicit wrap so non-power-of-2 requester counts rotate correctly.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick, searching
// from i_ptr upward and wrapping modulo NUM_REQ.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] w_k;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = IW'(rr_wrap(int'(i_ptr) + i, NUM_REQ));
            if (!o_valid && i_req[w_k]) begin
                o_valid    = 1'b1;
                o_idx      = w_k;
                o_gnt[w_k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one 8N1 TX line between NUM_REQ byte
// requesters; round-robin grant, clock-enable bit divider.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = UART_DEF_CLK_DIV
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*8-1:0]       i_data,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic                       o_txd,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t                r_state;
    uart_state_t                w_state_n;
    logic [CW-1:0]              r_bit_cnt;
    logic [CW-1:0]              w_bit_cnt_n;
    logic [2:0]                 r_bit_idx;
    logic [2:0]                 w_bit_idx_n;
    logic [2:0]                 w_bit_idx_p1;
    logic [UART_DATA_BITS-1:0]  r_shreg;
    logic [UART_DATA_BITS-1:0]  w_shreg_n;
    logic [UART_DATA_BITS-1:0]  w_sel_byte;
    logic [IW-1:0]              r_rr_ptr;
    logic [IW-1:0]              w_rr_ptr_n;
    logic [IW-1:0]              r_grant_id;
    logic [IW-1:0]              w_grant_id_n;
    logic [NUM_REQ-1:0]         r_ack;
    logic [NUM_REQ-1:0]         w_ack_n;
    logic                       r_txd;
    logic                       w_txd_n;
    logic                       r_busy;
    logic                       w_busy_n;

    logic [NUM_REQ-1:0]         w_gnt;
    logic [IW-1:0]              w_idx;
    logic                       w_valid;
    logic                       w_tick;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_tick       = (r_bit_cnt == LAST_CNT);
    assign w_bit_idx_p1 = r_bit_idx + 3'd1;

    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_byte = i_data[i*8 +: 8];
            end
        end
    end

    // Outputs are registered, so each branch computes the value
    // the line must carry in the cycle after this edge.
    always_comb begin
        w_state_n    = r_state;
        w_bit_cnt_n  = (r_state == IDLE || w_tick) ? '0 : r_bit_cnt + CW'(1);
        w_bit_idx_n  = r_bit_idx;
        w_shreg_n    = r_shreg;
        w_rr_ptr_n   = r_rr_ptr;
        w_grant_id_n = r_grant_id;
        w_ack_n      = '0;
        w_txd_n      = 1'b1;
        w_busy_n     = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_busy_n = 1'b0;
                if (w_valid) begin
                    w_state_n    = START;
                    w_shreg_n    = w_sel_byte;
                    w_grant_id_n = w_idx;
                    w_rr_ptr_n   = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
                    w_ack_n      = w_gnt;
                    w_txd_n      = 1'b0;
                    w_busy_n     = 1'b1;
                end
            end
            START: begin
                w_txd_n = 1'b0;
                if (w_tick) begin
                    w_state_n   = DATA;
                    w_bit_idx_n = '0;
                    w_txd_n     = r_shreg[0];
                end
            end
            DATA: begin
                w_txd_n = r_shreg[r_bit_idx];
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_n = STOP;
                        w_txd_n   = 1'b1;
                    end else begin
                        w_bit_idx_n = w_bit_idx_p1;
                        w_txd_n     = r_shreg[w_bit_idx_p1];
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_n = IDLE;
                    w_busy_n  = 1'b0;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_ack      <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_bit_idx  <= w_bit_idx_n;
            r_shreg    <= w_shreg_n;
            r_rr_ptr   <= w_rr_ptr_n;
            r_grant_id <= w_grant_id_n;
            r_ack      <= w_ack_n;
            r_txd      <= w_txd_n;
            r_busy     <= w_busy_n;
        end
    end

    assign o_ack      = r_ack;
    assign o_txd      = r_txd;
    assign o_busy     = r_busy;
    assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: vector table, directed corner sequences and
// random traffic against a frame-timing reference model.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int FL = 10 * D;

    typedef struct packed {
        logic [N-1:0] req;
        logic         txd;
        logic         busy;
        logic [N-1:0] ack;
        logic [1:0]   gid;
    } vec_t;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic [N-1:0] req  = '0;
    logic [N*8-1:0] data = '0;
    logic [N-1:0] ack;
    logic         txd;
    logic         busy;
    logic [1:0]   gid;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ (N),
        .CLK_DIV (D)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_data     (data),
        .o_ack      (ack),
        .o_txd      (txd),
        .o_busy     (busy),
        .o_grant_id (gid)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: a frame is "age" cycles old since its grant.
    bit           m_act = 1'b0;
    int           m_age = 0;
    logic [7:0]   m_byte = '0;
    int           m_gid = 0;
    int           m_ptr = 0;
    logic [N-1:0] m_ack = '0;

    int acyc[$];
    int aid[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        if ($countones(v) == 1)
            for (int i = 0; i < N; i++)
                if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic m_txd();
        if (!m_act) return 1'b1;
        if (m_age <= D) return 1'b0;
        if (m_age <= 9 * D) return m_byte[(m_age - 1) / D - 1];
        return 1'b1;
    endfunction

    task automatic model_edge();
        int w;
        w = -1;
        m_ack = '0;
        if (rst) begin
            m_act = 1'b0;
            m_gid = 0;
            m_ptr = 0;
        end else if (m_act) begin
            m_age++;
            if (m_age > FL) m_act = 1'b0;
        end else begin
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_act    = 1'b1;
                m_age    = 1;
                m_byte   = data[w*8 +: 8];
                m_gid    = w;
                m_ptr    = (w + 1) % N;
                m_ack[w] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("model_txd", txd, m_txd());
        chk("model_busy", busy, m_act);
        chk("model_ack", ack, m_ack);
        chk("model_gid", gid, m_gid);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 100) begin
            step();
            t++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic wait_ack(input string nm, input logic [N-1:0] exp);
        int t;
        t = 0;
        while (ack == '0 && t < 100) begin
            step();
            t++;
        end
        chk(nm, ack, exp);
    endtask

    initial begin
        vec_t tbl [41];
        logic fb [10];
        int   exp_fair [4];
        int   n;
        int   n_ack1;
        int   rerise;
        bit   fell;

        // Reset held for three cycles, then released with no request.
        rst = 1'b1;
        req = '0;
        repeat (3) begin
            step();
            chk("rst_txd", txd, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_ack", ack, 4'b0000);
            chk("rst_gid", gid, 2'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("post_rst_txd", txd, 1'b1);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_ack", ack, 4'b0000);
            chk("post_rst_gid", gid, 2'd0);
        end

        // Single request: port 2, byte 0xA5, one record per cycle.
        fb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int j = 0; j < 41; j++) begin
            tbl[j].req  = (j == 0) ? 4'b0100 : 4'b0000;
            tbl[j].txd  = (j < 40) ? fb[j / 4] : 1'b1;
            tbl[j].busy = (j < 40);
            tbl[j].ack  = (j == 0) ? 4'b0100 : 4'b0000;
            tbl[j].gid  = 2'd2;
        end
        data[23:16] = 8'hA5;
        for (int j = 0; j < 41; j++) begin
            req = tbl[j].req;
            step();
            chk("single_txd", txd, tbl[j].txd);
            chk("single_busy", busy, tbl[j].busy);
            chk("single_ack", ack, tbl[j].ack);
            chk("single_gid", gid, tbl[j].gid);
        end

        // All four requesters from reset, each dropped after its ack.
        rst = 1'b1;
        req = '0;
        step();
        rst  = 1'b0;
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = '1;
        acyc.delete();
        aid.delete();
        for (int t = 0; t < 250 && aid.size() < 4; t++) begin
            step();
            if (ack != '0) begin
                chk("all_order", onehot_idx(ack), aid.size());
                chk("all_gid", gid, aid.size());
                aid.push_back(onehot_idx(ack));
                acyc.push_back(cyc);
                req = req & ~ack;
            end
        end
        chk("all_count", aid.size(), 4);
        for (int i = 1; i < acyc.size(); i++)
            chk("all_pitch", acyc[i] - acyc[i-1], FL + 1);
        wait_idle();

        // Fairness: steer rr_ptr to 2 through port 1, then hold 1010.
        data[15:8] = 8'h5A;
        req = 4'b0010;
        wait_ack("fair_setup_ack", 4'b0010);
        data[15:8]  = 8'hC3;
        data[31:24] = 8'h3C;
        req = 4'b1010;
        exp_fair = '{3, 1, 3, 1};
        n = 0;
        for (int t = 0; t < 250 && n < 4; t++) begin
            step();
            if (ack != '0) begin
                chk("fair_order", onehot_idx(ack), exp_fair[n]);
                n++;
            end
        end
        chk("fair_count", n, 4);

        // Reset in the first cycle of data bit 3 of the port-1 frame.
        repeat (16) step();
        rst = 1'b1;
        step();
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ack", ack, 4'b0000);
        rst = 1'b0;
        req = '1;
        wait_ack("midrst_first_grant", 4'b0001);
        chk("midrst_first_gid", gid, 2'd0);
        req = '0;

        // Withdrawal: a one-cycle req[1] pulse while the line is busy.
        repeat (5) step();
        req = 4'b0010;
        step();
        req = '0;
        n_ack1 = 0;
        rerise = 0;
        fell   = 1'b0;
        repeat (60) begin
            step();
            if (ack[1]) n_ack1++;
            if (!busy) fell = 1'b1;
            else if (fell) rerise++;
        end
        chk("wd_ack1", n_ack1, 0);
        chk("wd_extra_frame", rerise, 0);
        chk("wd_idle", busy, 1'b0);

        // Random traffic honouring the requester contract.
        for (int t = 0; t < 3000; t++) begin
            for (int p = 0; p < N; p++) begin
                if (req[p]) begin
                    if (ack[p]) begin
                        if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
                        else data[p*8 +: 8] = 8'($urandom);
                    end else if ($urandom_range(0, 39) == 0) begin
                        req[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req[p] = 1'b1;
                    data[p*8 +: 8] = 8'($urandom);
                end
            end
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;
        req = '0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
